// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types for the BRAM port arbiter and its read-tag pipe
package bram_arb_pkg;
  localparam int DEF_RD_LATENCY = 1;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
  typedef enum logic {ST_NORMAL = 1'b0, ST_BOOST = 1'b1} arb_state_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;
endpackage

// File: rtl/bram_port_arbiter_tag_pipe.sv
// arb_tag_pipe: delays read tags by the BRAM read latency so data returns to its owner
module arb_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic iwClk,
  input  logic iwnRst,
  input  tag_t iwTag,
  output tag_t owTag
);
  tag_t [RD_LATENCY-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = iwTag;
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge iwClk or negedge iwnRst)
    if (!iwnRst) pipe_q <= '0;
    else pipe_q <= pipe_d;
  assign owTag = pipe_q[RD_LATENCY-1];
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM between fetch (read) and load/store, D-priority with I starvation guard
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int STARVE_MAX = 4
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwIReq,
  input  logic [31:0] iwIAddr,
  output logic        owIGnt,
  output logic        owIRvalid,
  output logic [31:0] owIRdata,
  input  logic        iwDReq,
  input  logic        iwDWe,
  input  logic [31:0] iwDAddr,
  input  logic [31:0] iwDWdata,
  input  logic [3:0]  iwDWstrb,
  output logic        owDGnt,
  output logic        owDRvalid,
  output logic [31:0] owDRdata,
  output logic [31:0] owMemReadAddr,
  output logic [31:0] owMemWriteAddr,
  output logic [31:0] owMemWriteData,
  output logic [3:0]  owMemWstrb,
  input  logic [31:0] iwMemReadData
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  arb_state_e    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   raddr_q, raddr_d, irdata_q, irdata_d, drdata_q, drdata_d;
  logic          store, load, raw, i_gnt, d_rd_gnt, i_ret, d_ret;
  tag_t          tag_in, tag_out;
  // grants are gated by reset so every output reads 0 while iwnRst is low
  assign store = iwnRst & iwDReq & iwDWe;
  assign load  = iwnRst & iwDReq & ~iwDWe;
  assign raw   = store & (iwIAddr[31:2] == iwDAddr[31:2]);
  always_ff @(posedge iwClk or negedge iwnRst)
    if (!iwnRst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  always_comb begin
    state_d  = i_gnt ? ST_NORMAL : (iwIReq & (starve_q == CW'(STARVE_MAX - 1))) ? ST_BOOST : state_q;
    starve_d = i_gnt ? '0 : (iwIReq & (starve_q != CW'(STARVE_MAX))) ? starve_q + 1'b1 : starve_q;
  end
  always_comb begin
    i_gnt    = iwnRst & iwIReq & ~raw & (~load | (state_q == ST_BOOST));
    d_rd_gnt = load & ~i_gnt;
  end
  always_comb begin
    raddr_d      = i_gnt ? iwIAddr : d_rd_gnt ? iwDAddr : raddr_q;
    tag_in.valid = i_gnt | d_rd_gnt;
    tag_in.owner = i_gnt ? OWN_I : OWN_D;
    i_ret        = tag_out.valid & (tag_out.owner == OWN_I);
    d_ret        = tag_out.valid & (tag_out.owner == OWN_D);
    irdata_d     = i_ret ? iwMemReadData : irdata_q;
    drdata_d     = d_ret ? iwMemReadData : drdata_q;
  end
  always_ff @(posedge iwClk or negedge iwnRst)
    if (!iwnRst) begin
      raddr_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      raddr_q  <= raddr_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  arb_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_pipe (
    .iwClk (iwClk),
    .iwnRst(iwnRst),
    .iwTag (tag_in),
    .owTag (tag_out)
  );
  assign owIGnt         = i_gnt;
  assign owDGnt         = store | d_rd_gnt;
  assign owMemReadAddr  = raddr_d;
  assign owMemWriteAddr = store ? iwDAddr : '0;
  assign owMemWriteData = store ? iwDWdata : '0;
  assign owMemWstrb     = store ? iwDWstrb : '0;
  assign owIRvalid      = i_ret;
  assign owDRvalid      = d_ret;
  assign owIRdata       = irdata_d;
  assign owDRdata       = drdata_d;
endmodule
